// File: rtl/keypad_entry.sv
// Keypad entry: debounces scanner key codes into single events and assembles a signed BCD command with an axis.
// Optional macro KEYPAD_ENTRY_ECHO_EN adds live display mirrors of the entry buffer, count, sign and axis.
module keypad_entry #(
  parameter int NDIGITS        = 4,
  parameter int RELEASE_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             key_code,
  input  logic                   released,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_bcd,
  output logic [1:0]             out_axis,
  output logic                   out_neg,
  output logic                   key_evt,
  output logic                   err
`ifdef KEYPAD_ENTRY_ECHO_EN
  ,
  output logic [4*NDIGITS-1:0]          disp_bcd,
  output logic [$clog2(NDIGITS+1)-1:0]  disp_count,
  output logic                          disp_neg,
  output logic [1:0]                    disp_axis
`endif
);

  localparam int BCD_W = 4 * NDIGITS;
  localparam int CNT_W = $clog2(NDIGITS + 1);
  localparam int QW    = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  typedef enum logic {S_HELD, S_IDLE} state_t;

  state_t             state;
  logic [QW-1:0]      quiet;
  logic [BCD_W-1:0]   entry;
  logic [CNT_W-1:0]   count;
  logic               neg;
  logic [1:0]         axis;

  logic               take;
  logic               is_digit;
  logic               room;
  logic               slot_free;
  logic               accept_f;

  function automatic logic [BCD_W-1:0] shift_in(input logic [BCD_W-1:0] e, input logic [3:0] d);
    return (e << 4) | BCD_W'(d);
  endfunction

  function automatic logic [BCD_W-1:0] shift_out(input logic [BCD_W-1:0] e);
    return e >> 4;
  endfunction

  always_comb begin
    take      = (state == S_IDLE) && !released;
    is_digit  = (key_code <= 4'd9);
    room      = (count < CNT_W'(NDIGITS));
    slot_free = !out_valid || out_ready;
    accept_f  = take && (key_code == 4'hF) && (count != '0) && slot_free;
  end

  // A key is captured and processed on the same edge, so key_evt and its effects appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HELD;
      quiet     <= '0;
      entry     <= '0;
      count     <= '0;
      neg       <= 1'b0;
      axis      <= 2'd0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_axis  <= 2'd0;
      out_neg   <= 1'b0;
      key_evt   <= 1'b0;
      err       <= 1'b0;
    end else begin
      key_evt <= 1'b0;
      err     <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        S_HELD: begin
          if (!released) begin
            quiet <= '0;
          end else if (quiet == QW'(RELEASE_CYCLES - 1)) begin
            quiet <= '0;
            state <= S_IDLE;
          end else begin
            quiet <= quiet + 1'b1;
          end
        end

        S_IDLE: begin
          if (take) begin
            key_evt <= 1'b1;
            quiet   <= '0;
            state   <= S_HELD;
            if (is_digit) begin
              if (room) begin
                entry <= shift_in(entry, key_code);
                count <= count + 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              case (key_code)
                4'hA: axis <= 2'd0;
                4'hB: axis <= 2'd1;
                4'hC: axis <= 2'd2;
                4'hD: neg  <= ~neg;
                4'hE: begin
                  // Backspace at an empty entry is silently ignored.
                  if (count != '0) begin
                    entry <= shift_out(entry);
                    count <= count - 1'b1;
                    if (count == CNT_W'(1))
                      neg <= 1'b0;
                  end
                end
                default: begin
                  if (accept_f) begin
                    out_bcd   <= entry;
                    out_axis  <= axis;
                    out_neg   <= neg;
                    out_valid <= 1'b1;
                    entry     <= '0;
                    count     <= '0;
                    neg       <= 1'b0;
                  end else begin
                    err <= 1'b1;
                  end
                end
              endcase
            end
          end
        end

        default: state <= S_HELD;
      endcase
    end
  end

`ifdef KEYPAD_ENTRY_ECHO_EN
  assign disp_bcd   = entry;
  assign disp_count = count;
  assign disp_neg   = neg;
  assign disp_axis  = axis;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: key presses with debounce, scoreboard of expected commands.
module tb_keypad_entry;
  localparam int ND = 4;
  localparam int RC = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      key_code = 4'h0;
  logic            released = 1'b1;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [4*ND-1:0] out_bcd;
  logic [1:0]      out_axis;
  logic            out_neg;
  logic            key_evt;
  logic            err;
`ifdef KEYPAD_ENTRY_ECHO_EN
  logic [4*ND-1:0]          disp_bcd;
  logic [$clog2(ND+1)-1:0]  disp_count;
  logic                     disp_neg;
  logic [1:0]               disp_axis;
`endif

  keypad_entry #(.NDIGITS(ND), .RELEASE_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .released(released),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_axis(out_axis), .out_neg(out_neg), .key_evt(key_evt), .err(err)
`ifdef KEYPAD_ENTRY_ECHO_EN
    , .disp_bcd(disp_bcd), .disp_count(disp_count), .disp_neg(disp_neg), .disp_axis(disp_axis)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*ND-1:0] bcd;
    logic [1:0]      axis;
    logic            neg;
  } cmd_t;

  cmd_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   evt_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Outputs are sampled on the falling edge; inputs change just after the rising edge.
  always @(negedge clk) begin
    if (rst_n && key_evt) evt_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_cmd", 32'(out_bcd), 32'hFFFF_FFFF);
      end else begin
        cmd_t e;
        e = sb.pop_front();
        chk("sb_bcd", 32'(out_bcd), 32'(e.bcd));
        chk("sb_axis", 32'(out_axis), 32'(e.axis));
        chk("sb_neg", 32'(out_neg), 32'(e.neg));
      end
    end
  end

  task automatic wait_quiet(input int n);
    released = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input string tag, input logic [3:0] k, input logic exp_err, input logic exp_vld);
    key_code = k;
    released = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_evt"}, 32'(key_evt), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_vld"}, 32'(out_valid), 32'(exp_vld));
    @(posedge clk); #1;
    chk({tag, "_evt_once"}, 32'(key_evt), 32'd0);
    wait_quiet(RC + 2);
  endtask

  task automatic push(input logic [4*ND-1:0] b, input logic [1:0] a, input logic n);
    cmd_t c;
    c.bcd = b; c.axis = a; c.neg = n;
    sb.push_back(c);
  endtask

  initial begin
    int e0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(out_bcd), 32'd0);
    chk("rst_axis", 32'(out_axis), 32'd0);
    chk("rst_neg", 32'(out_neg), 32'd0);
    chk("rst_evt", 32'(key_evt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_quiet(RC + 2);

    // 1,2,3, axis Y, enter
    press("t1_d1", 4'h1, 1'b0, 1'b0);
    press("t1_d2", 4'h2, 1'b0, 1'b0);
    press("t1_d3", 4'h3, 1'b0, 1'b0);
    press("t1_B", 4'hB, 1'b0, 1'b0);
    push(16'h0123, 2'd1, 1'b0);
    press("t1_F", 4'hF, 1'b0, 1'b1);
    press("t1_F_empty", 4'hF, 1'b1, 1'b0);

    // Held key with scanner chatter yields one event
    e0 = evt_cnt;
    key_code = 4'h5;
    for (int i = 0; i < 6; i++) begin
      released = 1'b0;
      repeat (3) @(posedge clk);
      released = 1'b1;
      repeat (3) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    key_code = 4'h6;
    released = 1'b0;
    repeat (2) @(posedge clk);
    wait_quiet(RC + 2);
    chk("t2_one_evt", 32'(evt_cnt), 32'(e0 + 1));
    press("t2_d6", 4'h6, 1'b0, 1'b0);
    push(16'h0056, 2'd1, 1'b0);
    press("t2_F", 4'hF, 1'b0, 1'b1);

    // Overflow, backspace
    press("t3_d1", 4'h1, 1'b0, 1'b0);
    press("t3_d2", 4'h2, 1'b0, 1'b0);
    press("t3_d3", 4'h3, 1'b0, 1'b0);
    press("t3_d4", 4'h4, 1'b0, 1'b0);
    press("t3_d5", 4'h5, 1'b1, 1'b0);
    press("t3_E1", 4'hE, 1'b0, 1'b0);
    press("t3_E2", 4'hE, 1'b0, 1'b0);
    push(16'h0012, 2'd1, 1'b0);
    press("t3_F", 4'hF, 1'b0, 1'b1);

    // Busy output slot
    out_ready = 1'b0;
    press("t4_d7", 4'h7, 1'b0, 1'b0);
    push(16'h0007, 2'd1, 1'b0);
    press("t4_F1", 4'hF, 1'b0, 1'b1);
    press("t4_d9", 4'h9, 1'b0, 1'b1);
    press("t4_F2", 4'hF, 1'b1, 1'b1);
    chk("t4_hold_bcd", 32'(out_bcd), 32'h0007);
    out_ready = 1'b1;
    push(16'h0009, 2'd1, 1'b0);
    key_code = 4'hF;
    released = 1'b0;
    @(posedge clk); #1;
    chk("t4_b2b_vld", 32'(out_valid), 32'd1);
    chk("t4_b2b_bcd", 32'(out_bcd), 32'h0009);
    chk("t4_b2b_err", 32'(err), 32'd0);
    wait_quiet(RC + 2);

    // Sign, then enter with empty entry
    press("t5_D", 4'hD, 1'b0, 1'b0);
    press("t5_d4", 4'h4, 1'b0, 1'b0);
    push(16'h0004, 2'd1, 1'b1);
    press("t5_F", 4'hF, 1'b0, 1'b1);
    press("t5_F_empty", 4'hF, 1'b1, 1'b0);

    // Reset while a key is held
    press("t6_d3", 4'h3, 1'b0, 1'b0);
    key_code = 4'h8;
    released = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_evt", 32'(key_evt), 32'd0);
    chk("t6_rst_vld", 32'(out_valid), 32'd0);
    chk("t6_rst_axis", 32'(out_axis), 32'd0);
    chk("t6_rst_bcd", 32'(out_bcd), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    e0 = evt_cnt;
    repeat (4) @(posedge clk);
    wait_quiet(RC + 2);
    chk("t6_no_evt", 32'(evt_cnt), 32'(e0));
    press("t6_d2", 4'h2, 1'b0, 1'b0);
    push(16'h0002, 2'd0, 1'b0);
    press("t6_F", 4'hF, 1'b0, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
